univ_shift_reg: RTL
===================

// Module: univ_shift_reg
// PURPOSE
//  Parametrised N-bit edge-triggered universal register: hold, shift right, shift left, parallel load.
//  Generalises the single-bit D flip-flop cell (D, C -> Q, nQ) to WIDTH bits, adding async reset,
//  clock enable and serial chaining. Used as a sequential benchmark and building block in simulator test designs.
// PARAMETERS
//  WIDTH      4     register width in bits, >= 1
//  RESET_VAL  0     value loaded into Q while R is high (WIDTH bits)
// PORTS
//  C    in   1      clock, rising-edge active
//  R    in   1      reset, asynchronous, active-high
//  E    in   1      clock enable; 0 = hold regardless of M
//  M    in   2      mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load
//  D    in   WIDTH  parallel load data
//  SIR  in   1      serial in for shift right (enters at MSB)
//  SIL  in   1      serial in for shift left (enters at LSB)
//  ROT  in   1      rotate select (active only with ROTATE_EN)
//  Q    out  WIDTH  register state
//  nQ   out  WIDTH  bitwise complement of Q, always ~Q
//  SOR  out  1      serial out right = Q[0]
//  SOL  out  1      serial out left  = Q[WIDTH-1]
// BEHAVIOUR
//  - One clock C; reset R asynchronous, active-high. R high: Q <= RESET_VAL immediately (no edge needed),
//    nQ = ~RESET_VAL, SOR/SOL follow Q. R dominates C, E, M at all times.
//  - Reset deasserted: state updates only on rising C edge; latency 1 edge from inputs to Q.
//  - E=0 at edge: Q unchanged. E=1: per M:
//      00: Q <= Q
//      01: Q <= {SIR, Q[WIDTH-1:1]}    (SOR shows bit shifted out before the edge)
//      10: Q <= {Q[WIDTH-2:0], SIL}
//      11: Q <= D
//  - WIDTH=1: mode 01 gives Q <= SIR, mode 10 gives Q <= SIL; no out-of-range slices generated.
//  - nQ, SOR, SOL purely combinational from Q; never glitch-free guarantee beyond Q itself.
//  - Reset asserted mid-operation (between edges or coincident with an edge): reset wins; first post-reset
//    edge with E=1 operates on RESET_VAL.
//  - R released coincident with C rising: no update on that edge; Q stays RESET_VAL.
//  - X/Z on M with E=1: Q goes X (no silent default).
// CONFIGURATION
//  - Macro USR_ROTATE_EN.
//  - Defined: with ROT=1, mode 01 MSB input is Q[0] (rotate right), mode 10 LSB input is Q[WIDTH-1]
//    (rotate left); SIR/SIL ignored while ROT=1. ROT=0 behaves as undefined case.
//  - Undefined: ROT port present but ignored; shifts always use SIR/SIL.
// STRUCTURE
//  - Shared include usr_defs.vh: `define constants for mode codes (USR_HOLD=2'b00, USR_SHR=2'b01,
//    USR_SHL=2'b10, USR_LOAD=2'b11), reused by benches.
//  - One sub-module usr_bit_cell: 4:1 next-value mux + enable + async-reset flop, ports
//    (C, R, E, M, hold, right_in, left_in, load_in, rst_val, Q); top instantiates WIDTH cells in a generate
//    loop and wires neighbour/serial/rotate inputs.
// TESTING  (WIDTH=4, RESET_VAL=4'b0000 unless noted)
//  1. R=1 at t=0, no clocks -> Q=0000, nQ=1111 immediately; R=1 mid-run with Q=1010 -> Q=0000 before next edge.
//  2. M=11, D=1011, E=1, one edge -> Q=1011, nQ=0100, SOL=1, SOR=1; then E=0, M=11, D=0000 -> Q stays 1011.
//  3. Q=1011, M=01, SIR=0, 4 edges -> Q: 0101, 0010, 0001, 0000; SOR sequence 1,1,0,1 before each edge.
//  4. Q=0001, M=10, SIL=1, 3 edges -> 0011, 0111, 1111.
//  5. USR_ROTATE_EN defined, ROT=1, Q=1000, M=10, 4 edges -> 0001, 0010, 0100, 1000; without macro -> SIL path.
//  6. RESET_VAL=4'b0110, R released coincident with rising C, M=11, D=1111 -> Q=0110 after that edge,
//     1111 after next edge.

Source files
------------

// File: rtl/univ_shift_reg_pkg.sv
// ============================================================================
// Module      : univ_shift_reg_pkg
// Description : Mode codes and helpers shared by the universal shift register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package univ_shift_reg_pkg;

   localparam int c_MODE_W = 2;

   typedef enum logic [c_MODE_W-1:0] {
      USR_HOLD = 2'b00,
      USR_SHR  = 2'b01,
      USR_SHL  = 2'b10,
      USR_LOAD = 2'b11
   } usr_mode_e;

   // Serial entry for an end cell: the opposite end of the word when rotating,
   // otherwise the external serial input.
   function automatic logic usr_pick_serial(input logic rot,
                                            input logic ring_bit,
                                            input logic serial_in);
      return rot ? ring_bit : serial_in;
   endfunction

endpackage

`default_nettype wire

// File: rtl/usr_bit_cell.sv
// ============================================================================
// Module      : usr_bit_cell
// Description : One bit of the universal register: 4:1 next-value mux,
//               clock enable and asynchronously reset flop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usr_bit_cell
   import univ_shift_reg_pkg::*;
(
   input  logic                C,
   input  logic                R,
   input  logic                E,
   input  logic [c_MODE_W-1:0] M,
   input  logic                hold,
   input  logic                right_in,
   input  logic                left_in,
   input  logic                load_in,
   input  logic                rst_val,
   output logic                Q
);

   logic w_next;

   // An unknown mode code propagates as X instead of falling back to hold.
   always_comb begin
      w_next = hold;
      case (M)
         USR_HOLD: w_next = hold;
         USR_SHR:  w_next = right_in;
         USR_SHL:  w_next = left_in;
         USR_LOAD: w_next = load_in;
         default:  w_next = 1'bx;
      endcase
   end

   always_ff @(posedge C or posedge R) begin
      if (R) begin
         Q <= rst_val;
      end else if (E) begin
         Q <= w_next;
      end
   end

endmodule

`default_nettype wire

// File: rtl/univ_shift_reg.sv
// ============================================================================
// Module      : univ_shift_reg
// Description : WIDTH-bit universal register (hold / shift right / shift left /
//               parallel load) with async reset, enable and serial chaining.
//               Build macro USR_ROTATE_EN enables rotate via ROT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module univ_shift_reg
   import univ_shift_reg_pkg::*;
#(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                C,
   input  logic                R,
   input  logic                E,
   input  logic [c_MODE_W-1:0] M,
   input  logic [WIDTH-1:0]    D,
   input  logic                SIR,
   input  logic                SIL,
   input  logic                ROT,
   output logic [WIDTH-1:0]    Q,
   output logic [WIDTH-1:0]    nQ,
   output logic                SOR,
   output logic                SOL
);

   logic w_sr_in;
   logic w_sl_in;

`ifdef USR_ROTATE_EN
   assign w_sr_in = usr_pick_serial(ROT, Q[0], SIR);
   assign w_sl_in = usr_pick_serial(ROT, Q[WIDTH-1], SIL);
`else
   logic w_unused_rot;
   assign w_unused_rot = ROT;
   assign w_sr_in      = SIR;
   assign w_sl_in      = SIL;
`endif

   // Cell i takes Q[i+1] on a right shift and Q[i-1] on a left shift; the end
   // cells take the serial inputs, so WIDTH=1 never references a neighbour.
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      logic w_right_in;
      logic w_left_in;

      if (i == WIDTH - 1) begin : g_msb_right
         assign w_right_in = w_sr_in;
      end else begin : g_inner_right
         assign w_right_in = Q[i+1];
      end

      if (i == 0) begin : g_lsb_left
         assign w_left_in = w_sl_in;
      end else begin : g_inner_left
         assign w_left_in = Q[i-1];
      end

      usr_bit_cell u_cell (
         .C        (C),
         .R        (R),
         .E        (E),
         .M        (M),
         .hold     (Q[i]),
         .right_in (w_right_in),
         .left_in  (w_left_in),
         .load_in  (D[i]),
         .rst_val  (RESET_VAL[i]),
         .Q        (Q[i])
      );
   end

   assign nQ  = ~Q;
   assign SOR = Q[0];
   assign SOL = Q[WIDTH-1];

endmodule

`default_nettype wire
